// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl
// Purpose  : Instruction-fetch sequencer for the MIPS core. Owns the program
//            counter, addresses a combinational instruction ROM and captures
//            the returned word into an IF register. The IF register uses a
//            valid/ready handshake toward decode. The block also handles
//            start/halt control, branch/jump redirects and address errors.
// Ports    :
//   clk            in   system clock, rising-edge active
//   rst_n          in   asynchronous active-low reset
//   start          in   leave IDLE/HALT and fetch from the held PC
//   halt_req       in   stop fetching after this cycle
//   pc_o           out  fetch address to the ROM
//   rom_inst_i     in   ROM data for pc_o (combinational)
//   redirect_valid in   branch/jump taken this cycle
//   redirect_pc    in   redirect target
//   if_valid       out  IF register holds a valid instruction
//   if_inst        out  fetched instruction
//   if_pc          out  PC of if_inst
//   if_ready       in   decode accepts if_inst this cycle
//   state_o        out  00 IDLE, 01 RUN, 10 HALT
//   err_o          out  sticky misaligned-redirect / PC-range error
//   fetch_cnt      out  saturating count of instructions latched into IF
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  output logic [31:0] pc_o,
  input  logic [31:0] rom_inst_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic [1:0]  state_o,
  output logic        err_o,
  output logic [31:0] fetch_cnt
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;

  localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;
  localparam logic [31:0] C_PC_STEP = 32'd4;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_inst;
  logic [31:0] r_if_pc;
  logic        r_err;
  logic [31:0] r_fetch_cnt;

  logic        w_acc;
  logic        w_redir_misaligned;
  logic        w_pc_out_of_range;

  // Control strobes produced by the output decode of the FSM
  logic        w_fetch;
  logic        w_flush;
  logic        w_pc_load;
  logic        w_err_set;
  logic        w_err_clr;

  // IF register can take a new word when empty or when decode drains it now
  assign w_acc              = !r_if_valid || if_ready;
  assign w_redir_misaligned = (redirect_pc[1:0] != 2'b00);

  // Any PC bit above the ROM word index means the address misses the ROM.
  // When the ROM spans the whole 32-bit space there is nothing to check.
  generate
    if (ROM_AW + 2 < 32) begin : g_range_chk
      assign w_pc_out_of_range = |r_pc[31:ROM_AW+2];
    end else begin : g_no_range_chk
      assign w_pc_out_of_range = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (redirect_valid) begin
          // A bad target halts; a good one still honours a concurrent halt
          if (w_redir_misaligned || halt_req) begin
            w_state_nxt = S_HALT;
          end
        end else if (halt_req || w_pc_out_of_range) begin
          w_state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        // start has priority over halt_req here
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM output decode: datapath control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_fetch   = 1'b0;
    w_flush   = 1'b0;
    w_pc_load = 1'b0;
    w_err_set = 1'b0;
    w_err_clr = 1'b0;
    case (r_state)
      S_RUN: begin
        if (redirect_valid) begin
          // Redirect always flushes, even if decode is ready this cycle
          w_flush = 1'b1;
          if (w_redir_misaligned) begin
            w_err_set = 1'b1;
          end else begin
            w_pc_load = 1'b1;
          end
        end else if (halt_req) begin
          // no fetch; IF contents drain through the normal consume path
        end else if (w_pc_out_of_range) begin
          w_err_set = 1'b1;
        end else if (w_acc) begin
          w_fetch = 1'b1;
        end
      end
      S_HALT: begin
        if (start) begin
          w_err_clr = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Program counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_pc_load) begin
      r_pc <= redirect_pc;
    end else if (w_fetch) begin
      r_pc <= r_pc + C_PC_STEP;
    end
  end

  // --------------------------------------------------------------------------
  // IF output register. A new fetch takes precedence over the consume rule,
  // so back-to-back handshakes keep if_valid high at one word per cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_if_inst  <= 32'h0000_0000;
      r_if_pc    <= 32'h0000_0000;
    end else if (w_fetch) begin
      r_if_valid <= 1'b1;
      r_if_inst  <= rom_inst_i;
      r_if_pc    <= r_pc;
    end else if (w_flush) begin
      r_if_valid <= 1'b0;
    end else if (r_if_valid && if_ready) begin
      r_if_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flag, cleared only by a restart from HALT
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (w_err_clr) begin
      r_err <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating fetch counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= 32'h0000_0000;
    end else if (w_fetch && (r_fetch_cnt != C_CNT_MAX)) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign pc_o      = r_pc;
  assign if_valid  = r_if_valid;
  assign if_inst   = r_if_inst;
  assign if_pc     = r_if_pc;
  assign state_o   = r_state;
  assign err_o     = r_err;
  assign fetch_cnt = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_ctrl
// Purpose  : Self-checking bench for inst_fetch_ctrl. A behavioural model
//            predicts every cycle's outputs and queues each instruction that
//            decode should receive; a monitor pops and compares the queue on
//            every observed handshake. Directed scenarios come first, then
//            randomized traffic with occasional asynchronous resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic [31:0] pc_o;
  logic [31:0] rom_inst_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [1:0]  state_o;
  logic        err_o;
  logic [31:0] fetch_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rom [256];
  logic [63:0] exp_q [$];

  // Reference model state (architectural view only)
  logic [1:0]  m_state;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ipc;
  logic [31:0] m_inst;
  logic        m_err;
  logic [31:0] m_cnt;

  inst_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .ROM_AW   (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt_req       (halt_req),
    .pc_o           (pc_o),
    .rom_inst_i     (rom_inst_i),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .state_o        (state_o),
    .err_o          (err_o),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM indexed by word address
  assign rom_inst_i = rom[pc_o[9:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 2'd0;
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_ipc   = 32'h0;
    m_inst  = 32'h0;
    m_err   = 1'b0;
    m_cnt   = 32'h0;
  endtask

  // One clock of the fetch rules, evaluated from the specification's priorities
  task automatic model_step(input bit s, input bit h, input bit rv,
                            input logic [31:0] rpc, input bit rdy);
    bit          fetch = 1'b0;
    bit          flush = 1'b0;
    logic [1:0]  ns    = m_state;
    logic [31:0] npc   = m_pc;
    if (m_valid && rdy) exp_q.push_back({m_ipc, m_inst});
    if (m_state == 2'd0) begin
      if (s) ns = 2'd1;
    end else if (m_state == 2'd2) begin
      if (s) begin
        ns    = 2'd1;
        m_err = 1'b0;
      end
    end else begin
      if (rv) begin
        flush = 1'b1;
        if (rpc % 4 != 0) begin
          m_err = 1'b1;
          ns    = 2'd2;
        end else begin
          npc = rpc;
          if (h) ns = 2'd2;
        end
      end else if (h) begin
        ns = 2'd2;
      end else if (m_pc >= 32'd1024) begin
        m_err = 1'b1;
        ns    = 2'd2;
      end else if (!m_valid || rdy) begin
        fetch = 1'b1;
      end
    end
    if (fetch) begin
      m_ipc   = m_pc;
      m_inst  = rom[m_pc / 4];
      m_valid = 1'b1;
      npc     = m_pc + 32'd4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end else if (flush || rdy) begin
      m_valid = 1'b0;
    end
    m_pc    = npc;
    m_state = ns;
  endtask

  // Drive one cycle of inputs, advance the model, and compare after the edge
  task automatic cycle(input bit s, input bit h, input bit rv,
                       input logic [31:0] rpc, input bit rdy);
    @(negedge clk);
    #1;
    start          = s;
    halt_req       = h;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    model_step(s, h, rv, rpc, rdy);
    @(posedge clk);
    #1;
    check("pc_o", pc_o, m_pc);
    check("state_o", {30'd0, state_o}, {30'd0, m_state});
    check("err_o", {31'd0, err_o}, {31'd0, m_err});
    check("fetch_cnt", fetch_cnt, m_cnt);
    check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("if_pc", if_pc, m_ipc);
      check("if_inst", if_inst, m_inst);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    @(negedge clk);
    #1;
    start          = 1'b0;
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_pc", pc_o, 32'h0);
    check("rst_state", {30'd0, state_o}, 32'd0);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_cnt", fetch_cnt, 32'h0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every handshake seen at the DUT must match the next queued word
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && if_valid && if_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL hs_unexpected actual_pc=%h required=none", if_pc);
        end else begin
          e = exp_q.pop_front();
          check("hs_pc", if_pc, e[63:32]);
          check("hs_inst", if_inst, e[31:0]);
        end
      end
    end
  end

  initial begin
    bit          s, h, rv, rdy;
    logic [31:0] rpc;
    int          k;

    rst_n          = 1'b0;
    start          = 1'b0;
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[1] = 32'h0043_0820;
    rom[4] = 32'h3426_800A;
    model_reset();

    do_reset();

    // Sequential fetch from reset
    cycle(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 32'h0, 1);
      if (i == 1) begin
        check("tp1_pc4", if_pc, 32'h4);
        check("tp1_inst4", if_inst, 32'h0043_0820);
      end
    end
    check("tp1_cnt", fetch_cnt, 32'd5);
    check("tp1_pc16", if_pc, 32'h10);
    check("tp1_inst16", if_inst, 32'h3426_800A);

    // Backpressure holds everything
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 32'h0, 0);
      check("tp2_pc_hold", pc_o, 32'h14);
      check("tp2_ifpc_hold", if_pc, 32'h10);
    end

    // Redirect under backpressure flushes, then refetches the target
    cycle(0, 0, 1, 32'h10, 0);
    check("tp3_flush", {31'd0, if_valid}, 32'd0);
    check("tp3_pc", pc_o, 32'h10);
    cycle(0, 0, 0, 32'h0, 1);
    check("tp3_ifpc", if_pc, 32'h10);
    check("tp3_inst", if_inst, 32'h3426_800A);

    // Misaligned redirect: error + HALT, restart clears and resumes at held pc
    cycle(0, 0, 1, 32'h6, 0);
    check("tp4_err", {31'd0, err_o}, 32'd1);
    check("tp4_state", {30'd0, state_o}, 32'd2);
    check("tp4_flush", {31'd0, if_valid}, 32'd0);
    cycle(1, 0, 0, 32'h0, 1);
    check("tp4_restart", {30'd0, state_o}, 32'd1);
    check("tp4_err_clr", {31'd0, err_o}, 32'd0);
    cycle(0, 0, 0, 32'h0, 1);
    check("tp4_resume", if_pc, 32'h14);

    // Range error one cycle after jumping past the ROM
    cycle(0, 0, 1, 32'h400, 1);
    check("tp5_pc", pc_o, 32'h400);
    cycle(0, 0, 0, 32'h0, 1);
    check("tp5_err", {31'd0, err_o}, 32'd1);
    check("tp5_state", {30'd0, state_o}, 32'd2);
    check("tp5_cnt", fetch_cnt, 32'd7);

    // Halt while decode stalls: IF word drains only when accepted
    do_reset();
    cycle(1, 0, 0, 32'h0, 0);
    cycle(0, 0, 0, 32'h0, 0);
    cycle(0, 1, 0, 32'h0, 0);
    check("tp6_halt", {30'd0, state_o}, 32'd2);
    check("tp6_hold", {31'd0, if_valid}, 32'd1);
    cycle(0, 0, 0, 32'h0, 0);
    check("tp6_hold2", {31'd0, if_valid}, 32'd1);
    cycle(0, 0, 0, 32'h0, 1);
    check("tp6_drain", {31'd0, if_valid}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) do_reset();
      s  = (m_state != 2'd1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      h  = ($urandom_range(0, 29) == 0);
      rv = ($urandom_range(0, 14) == 0);
      // Steer out of an out-of-range PC so runs do not stall in HALT forever
      if (m_pc >= 32'd1024 && m_state == 2'd1 && $urandom_range(0, 3) != 0) rv = 1'b1;
      k = $urandom_range(0, 9);
      if (k == 0)      rpc = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
      else if (k == 1) rpc = 32'h400 + ($urandom_range(0, 15) << 2);
      else             rpc = $urandom_range(0, 255) << 2;
      rdy = ($urandom_range(0, 3) != 0);
      cycle(s, h, rv, rpc, rdy);
    end

    @(negedge clk);
    #5;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
